// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, register indices, fetch defaults and fetch-state encoding.
// Used by the fetch unit, instruction memory and decoder.
package cpu_defs;

    localparam int unsigned PC_W_DEFAULT    = 8;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam logic [4:0] OP_JUMP = 5'b00010;
    localparam logic [4:0] OP_BEQ  = 5'b00011;
    localparam logic [4:0] OP_BNE  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01001;

    localparam logic [2:0] GR0 = 3'd0;
    localparam logic [2:0] GR1 = 3'd1;
    localparam logic [2:0] GR2 = 3'd2;
    localparam logic [2:0] GR3 = 3'd3;
    localparam logic [2:0] GR4 = 3'd4;
    localparam logic [2:0] GR5 = 3'd5;
    localparam logic [2:0] GR6 = 3'd6;
    localparam logic [2:0] GR7 = 3'd7;

    localparam logic [15:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, hold freezes everything, load captures a new word.
// When none of these is asserted the slot is marked empty.
module if_id_reg import cpu_defs::*; #(
    parameter int unsigned PC_W = PC_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            load_i,
    input  logic [15:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [15:0]     instr_o,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o
);

    logic [15:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (hold_i) begin
            valid_d = valid_q;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register and IDLE/RUN/HALTED control, feeding the IF/ID register.
// Redirects beat stalls, stalls beat normal fetch; a HALT word parks the PC on itself.
module fetch_unit import cpu_defs::*; #(
    parameter int unsigned PC_W    = PC_W_DEFAULT,
    parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic            if_id_valid,
    output logic            halted,
    output logic [15:0]     fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     fetch_count_q, fetch_count_d;
    logic            flush, hold, load;
    logic [PC_W-1:0] redirect_pc;
    logic            unused_tgt_lsbs;

    // Redirects are forced word-aligned.
    assign redirect_pc     = {branch_target[PC_W-1:2], 2'b00};
    assign unused_tgt_lsbs = ^branch_target[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        hold    = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (branch_taken) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end else if (stall) begin
                    hold = 1'b1;
                end else begin
                    load = 1'b1;
                    if (is_halt(imem_rdata)) state_d = StHalted;
                    else                     pc_d    = pc_q + PC_W'(PC_STEP);
                end
            end
            StHalted: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    flush   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (load && fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .PC_W(PC_W)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (flush),
        .hold_i  (hold),
        .load_i  (load),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .valid_o (if_id_valid)
    );

    assign imem_addr   = pc_q;
    assign halted      = (state_q == StHalted);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected IF/ID contents, a negedge monitor
// pops and compares whenever a fresh instruction is presented.
module tb_fetch_unit;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    exp_t        exp_q [$];
    logic        stall_e;
    int          n_checks;
    int          n_fail;

    // Reference model state: 0 idle, 1 run, 2 halted
    int          m_state;
    logic [7:0]  m_pc;

    fetch_unit #(
        .PC_W    (8),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input logic st, input logic sl, input logic br, input logic [7:0] tgt);
        start         = st;
        stall         = sl;
        branch_taken  = br;
        branch_target = tgt;
        if (m_state != 0 && br) begin
            m_pc    = {tgt[7:2], 2'b00};
            m_state = 1;
        end else if (m_state == 0) begin
            if (st) m_state = 1;
        end else if (m_state == 1 && !sl) begin
            exp_q.push_back('{instr: mem[m_pc], pc: m_pc});
            if (mem[m_pc][15:11] == 5'b00001) m_state = 2;
            else                              m_pc = m_pc + 8'd4;
        end
        @(posedge clk);
        #1;
        start        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_pc    = 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   32'(imem_addr),   32'h0);
        check({tag, "_instr"},  32'(if_id_instr), 32'h0);
        check({tag, "_ifpc"},   32'(if_id_pc),    32'h0);
        check({tag, "_valid"},  32'(if_id_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted),      32'h0);
        check({tag, "_count"},  32'(fetch_count), 32'h0);
    endtask

    always @(posedge clk) stall_e <= stall;

    always @(negedge clk) begin
        if (!reset && if_id_valid && !stall_e) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got instr %0h pc %0h, required no valid word",
                         if_id_instr, if_id_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", 32'(if_id_instr), 32'(e.instr));
                check("sb_pc",    32'(if_id_pc),    32'(e.pc));
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        stall_e       = 1'b0;
        reset         = 1'b1;
        start         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'd0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h4A00 | 16'(a);
        mem[0]  = 16'h49AB;
        mem[88] = 16'h0800;
        model_reset();

        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Branch in IDLE is ignored
        step(1'b0, 1'b0, 1'b1, 8'd40);
        step(1'b0, 1'b0, 1'b1, 8'd40);
        check("idle_addr",  32'(imem_addr),   32'h0);
        check("idle_valid", 32'(if_id_valid), 32'h0);

        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("start_addr",  32'(imem_addr),   32'h0);
        check("start_valid", 32'(if_id_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("first_instr", 32'(if_id_instr), 32'h49AB);
        check("first_pc",    32'(if_id_pc),    32'h0);
        check("first_addr",  32'(imem_addr),   32'h4);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("pre_stall_addr", 32'(imem_addr), 32'd16);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0);
            check("stall_addr",  32'(imem_addr),   32'd16);
            check("stall_ifpc",  32'(if_id_pc),    32'd12);
            check("stall_valid", 32'(if_id_valid), 32'h1);
            check("stall_count", 32'(fetch_count), 32'd4);
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("resume_ifpc",  32'(if_id_pc),    32'd16);
        check("resume_addr",  32'(imem_addr),   32'd20);
        check("resume_count", 32'(fetch_count), 32'd5);

        // Branch outranks a simultaneous stall
        step(1'b0, 1'b1, 1'b1, 8'd61);
        check("br_addr",  32'(imem_addr),   32'd60);
        check("br_valid", 32'(if_id_valid), 32'h0);
        check("br_count", 32'(fetch_count), 32'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("br_instr",  32'(if_id_instr), 32'h4A3C);
        check("br_ifpc",   32'(if_id_pc),    32'd60);
        check("br_valid1", 32'(if_id_valid), 32'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("pre_halt_addr", 32'(imem_addr), 32'd88);

        // HALT on the bus during a stall must wait
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("halt_stall_halted", 32'(halted),    32'h0);
        check("halt_stall_addr",   32'(imem_addr), 32'd88);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("halt_instr",  32'(if_id_instr), 32'h0800);
        check("halt_valid",  32'(if_id_valid), 32'h1);
        check("halt_ifpc",   32'(if_id_pc),    32'd88);
        check("halt_addr",   32'(imem_addr),   32'd88);
        check("halt_flag",   32'(halted),      32'h1);
        check("halt_count",  32'(fetch_count), 32'd13);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("halted_valid", 32'(if_id_valid), 32'h0);
        check("halted_flag",  32'(halted),      32'h1);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        check("halted_start_flag", 32'(halted),      32'h1);
        check("halted_start_addr", 32'(imem_addr),   32'd88);
        check("halted_start_vld",  32'(if_id_valid), 32'h0);

        step(1'b0, 1'b0, 1'b1, 8'd68);
        check("unhalt_flag",  32'(halted),      32'h0);
        check("unhalt_addr",  32'(imem_addr),   32'd68);
        check("unhalt_valid", 32'(if_id_valid), 32'h0);
        check("unhalt_count", 32'(fetch_count), 32'd13);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("unhalt_instr", 32'(if_id_instr), 32'h4A44);
        check("unhalt_ifpc",  32'(if_id_pc),    32'd68);
        check("unhalt_addr2", 32'(imem_addr),   32'd72);
        check("unhalt_cnt2",  32'(fetch_count), 32'd14);

        // NOP memory: PC wrap and counter saturation
        reset = 1'b1;
        model_reset();
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        #1;
        check_reset_outputs("rst1");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("wrap_pre_addr", 32'(imem_addr), 32'd252);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("wrap_addr", 32'(imem_addr), 32'd0);
        check("wrap_ifpc", 32'(if_id_pc),  32'd252);
        for (int i = 0; i < 65534 - 64; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("sat_fffe", 32'(fetch_count), 32'hFFFE);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("sat_ffff", 32'(fetch_count), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("sat_hold", 32'(fetch_count), 32'hFFFF);

        // Asynchronous reset mid-cycle, well before the next rising edge
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("post_rst_valid", 32'(if_id_valid), 32'h0);
        check("post_rst_addr",  32'(imem_addr),   32'h0);
        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
